// File: rtl/conv3x3_feeder_if.sv
`default_nettype none
// conv3x3_feeder_if: control, weight-load, pixel-memory and multiplier/accumulator
// signals of the 3x3 convolution operand feeder.
interface conv3x3_feeder_if #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int AW    = 6
);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  logic          start;
  logic          stall;
  logic          w_wr_en;
  logic [3:0]    w_addr;
  logic [7:0]    w_data;
  logic          pix_rd_en;
  logic [AW-1:0] pix_addr;
  logic [7:0]    pix_data;
  logic          mul_valid;
  logic [7:0]    mul_a;
  logic [7:0]    mul_b;
  logic          sum_valid;
  logic [RW-1:0] out_row;
  logic [CW-1:0] out_col;
  logic          busy;
  logic          done;

  modport master (
    input  start, stall, w_wr_en, w_addr, w_data, pix_data,
    output pix_rd_en, pix_addr, mul_valid, mul_a, mul_b,
           sum_valid, out_row, out_col, busy, done
  );

  modport slave (
    output start, stall, w_wr_en, w_addr, w_data, pix_data,
    input  pix_rd_en, pix_addr, mul_valid, mul_a, mul_b,
           sum_valid, out_row, out_col, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/conv3x3_feeder.sv
`default_nettype none
// conv3x3_feeder: walks every valid 3x3 window in raster order and streams nine
// (pixel, weight) taps per window to a combinational multiplier and accumulator.
module conv3x3_feeder #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             rst,
  conv3x3_feeder_if.master bus
);
  localparam int            RW       = $clog2(IMG_H);
  localparam int            CW       = $clog2(IMG_W);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 3);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 3);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;

  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [1:0]    dr;
  logic [1:0]    dc;
  logic [3:0]    tap;
  logic [7:0]    weights [0:8];

  logic          rd_en;
  logic          busy_int;
  logic          tap_last;
  logic          win_last;
  logic [AW-1:0] rd_addr;

  logic          d_valid;
  logic          d_last;
  logic          d_final;
  logic [7:0]    d_weight;
  logic [RW-1:0] d_row;
  logic [CW-1:0] d_col;

  logic          s_valid;
  logic          s_done;
  logic [RW-1:0] s_row;
  logic [CW-1:0] s_col;

  assign tap      = 4'(dr) * 4'd3 + 4'(dc);
  assign tap_last = (dr == 2'd2) && (dc == 2'd2);
  assign win_last = tap_last && (row == ROW_LAST) && (col == COL_LAST);
  assign rd_addr  = (AW'(row) + AW'(dr)) * AW'(IMG_W) + AW'(col) + AW'(dc);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // DRAIN stays until the final sum flag so a new start is only taken afterwards.
  always_comb begin
    state_next = state;
    rd_en      = 1'b0;
    busy_int   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        busy_int = 1'b1;
        if (!bus.stall) begin
          rd_en = 1'b1;
          if (win_last) begin
            state_next = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        busy_int = !s_done;
        if (s_done) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row <= '0;
      col <= '0;
      dr  <= '0;
      dc  <= '0;
    end else if (state == S_IDLE) begin
      row <= '0;
      col <= '0;
      dr  <= '0;
      dc  <= '0;
    end else if (rd_en) begin
      if (dc != 2'd2) begin
        dc <= dc + 2'd1;
      end else begin
        dc <= '0;
        if (dr != 2'd2) begin
          dr <= dr + 2'd1;
        end else begin
          dr <= '0;
          if (col != COL_LAST) begin
            col <= col + 1'b1;
          end else begin
            col <= '0;
            row <= (row != ROW_LAST) ? row + 1'b1 : '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 9; i++) begin
        weights[i] <= '0;
      end
    end else if (bus.w_wr_en && !busy_int && (bus.w_addr <= 4'd8)) begin
      weights[bus.w_addr] <= bus.w_data;
    end
  end

  // Data stage: aligned with pix_data returning from memory.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_valid  <= 1'b0;
      d_last   <= 1'b0;
      d_final  <= 1'b0;
      d_weight <= '0;
      d_row    <= '0;
      d_col    <= '0;
    end else begin
      d_valid  <= rd_en;
      d_last   <= tap_last;
      d_final  <= win_last;
      d_weight <= weights[tap];
      d_row    <= row;
      d_col    <= col;
    end
  end

  // Sum stage: the accumulator has absorbed tap 8 by this cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_valid <= 1'b0;
      s_done  <= 1'b0;
      s_row   <= '0;
      s_col   <= '0;
    end else begin
      s_valid <= d_valid && d_last;
      s_done  <= d_valid && d_last && d_final;
      if (d_valid && d_last) begin
        s_row <= d_row;
        s_col <= d_col;
      end
    end
  end

  assign bus.pix_rd_en = rd_en;
  assign bus.pix_addr  = rd_addr;
  assign bus.mul_valid = d_valid;
  assign bus.mul_a     = bus.pix_data;
  assign bus.mul_b     = d_weight;
  assign bus.sum_valid = s_valid;
  assign bus.out_row   = s_row;
  assign bus.out_col   = s_col;
  assign bus.busy      = busy_int;
  assign bus.done      = s_done;

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_feeder.sv
`default_nettype none
// tb_conv3x3_feeder: scoreboard bench with a behavioural pixel memory and accumulator.
module tb_conv3x3_feeder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  conv3x3_feeder_if #(.IMG_W(8), .IMG_H(8), .AW(6)) bus ();

  conv3x3_feeder #(.IMG_W(8), .IMG_H(8), .AW(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct {
    int row;
    int col;
    int sum;
    int cyc;
    bit last;
  } exp_t;

  exp_t       expq[$];
  exp_t       exp_e;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         t0 = 0;
  int         npulse = 0;
  int         mv_cnt = 0;
  int         mv_lo = 0;
  int         mv_hi = -1;
  int         wt[9];
  logic [7:0] mem_q = 8'd0;
  logic [19:0] acc;
  logic [3:0]  acc_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  // Pixel memory: value at address r*8+c is r*8+c.
  always @(posedge clk) if (bus.pix_rd_en) mem_q <= 8'(bus.pix_addr);
  assign bus.pix_data = mem_q;

  // Accumulator restarts every 9 valid taps and shares the feeder reset.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc     <= '0;
      acc_cnt <= '0;
    end else if (bus.mul_valid) begin
      acc     <= ((acc_cnt == 4'd0) ? 20'd0 : acc) + 20'(bus.mul_a) * 20'(bus.mul_b);
      acc_cnt <= (acc_cnt == 4'd8) ? 4'd0 : acc_cnt + 4'd1;
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (bus.mul_valid && (cyc - t0) >= mv_lo && (cyc - t0) <= mv_hi) mv_cnt++;
      if (bus.sum_valid) begin
        npulse++;
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL sum_unexpected at cycle %0d row %0d col %0d", cyc - t0, bus.out_row, bus.out_col);
        end else begin
          exp_e = expq.pop_front();
          checks += 6;
          if (bus.out_row !== exp_e.row) begin errors++; $display("FAIL out_row got %0d want %0d", bus.out_row, exp_e.row); end
          if (bus.out_col !== exp_e.col) begin errors++; $display("FAIL out_col got %0d want %0d", bus.out_col, exp_e.col); end
          if (acc !== 20'(exp_e.sum)) begin errors++; $display("FAIL acc_sum (%0d,%0d) got %0d want %0d", exp_e.row, exp_e.col, acc, exp_e.sum); end
          if ((cyc - t0) !== exp_e.cyc) begin errors++; $display("FAIL sum_cycle (%0d,%0d) got %0d want %0d", exp_e.row, exp_e.col, cyc - t0, exp_e.cyc); end
          if (bus.done !== exp_e.last) begin errors++; $display("FAIL done_flag (%0d,%0d) got %0b want %0b", exp_e.row, exp_e.col, bus.done, exp_e.last); end
          if (bus.busy !== !exp_e.last) begin errors++; $display("FAIL busy_at_sum (%0d,%0d) got %0b want %0b", exp_e.row, exp_e.col, bus.busy, !exp_e.last); end
        end
      end else if (bus.done) begin
        checks++; errors++;
        $display("FAIL done_without_sum at cycle %0d", cyc - t0);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic advance_to(input int n);
    while ((cyc - t0) < n) tick();
  endtask

  task automatic write_w(input int addr, input int data);
    bus.w_wr_en = 1'b1; bus.w_addr = 4'(addr); bus.w_data = 8'(data);
    tick();
    bus.w_wr_en = 1'b0;
  endtask

  task automatic load_weights(input bit center_only);
    for (int k = 0; k < 9; k++) begin
      wt[k] = center_only ? ((k == 4) ? 1 : 0) : 1;
      write_w(k, wt[k]);
    end
  endtask

  function automatic int calc_sum(input int r, input int c);
    int s = 0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        s += wt[3*dr+dc] * (((r + dr) * 8 + c + dc) & 255);
    return s;
  endfunction

  // Pushes the whole pass into the scoreboard, then pulses start (cycle 0).
  task automatic start_pass(input int extra);
    exp_t e;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) begin
        e.row = r; e.col = c; e.sum = calc_sum(r, c);
        e.cyc = 11 + 9 * (r * 6 + c) + extra;
        e.last = (r == 5 && c == 5);
        expq.push_back(e);
      end
    npulse = 0;
    bus.start = 1'b1; t0 = cyc;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int exp_cyc);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 1000) begin
      @(negedge clk); n++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    checks += 2;
    if (!seen) begin
      errors++; $display("FAIL done_timeout after %0d cycles", n);
    end else if ((cyc - t0) !== exp_cyc) begin
      errors++; $display("FAIL done_cycle got %0d want %0d", cyc - t0, exp_cyc);
    end
    @(negedge clk);
    if (bus.busy !== 1'b0 || bus.sum_valid !== 1'b0) begin
      errors++; $display("FAIL post_done_idle busy %0b sum_valid %0b want 0 0", bus.busy, bus.sum_valid);
    end
    tick();
    checks += 2;
    if (expq.size() != 0) begin errors++; $display("FAIL queue_left got %0d want 0", expq.size()); end
    if (npulse != 36) begin errors++; $display("FAIL pulse_count got %0d want 36", npulse); end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks += 10;
    if (bus.pix_rd_en !== 1'b0) begin errors++; $display("FAIL %s pix_rd_en got %0b want 0", tag, bus.pix_rd_en); end
    if (bus.pix_addr !== 6'd0) begin errors++; $display("FAIL %s pix_addr got %0d want 0", tag, bus.pix_addr); end
    if (bus.mul_valid !== 1'b0) begin errors++; $display("FAIL %s mul_valid got %0b want 0", tag, bus.mul_valid); end
    if (bus.mul_a !== mem_q) begin errors++; $display("FAIL %s mul_a got %0d want %0d", tag, bus.mul_a, mem_q); end
    if (bus.mul_b !== 8'd0) begin errors++; $display("FAIL %s mul_b got %0d want 0", tag, bus.mul_b); end
    if (bus.sum_valid !== 1'b0) begin errors++; $display("FAIL %s sum_valid got %0b want 0", tag, bus.sum_valid); end
    if (bus.out_row !== 3'd0) begin errors++; $display("FAIL %s out_row got %0d want 0", tag, bus.out_row); end
    if (bus.out_col !== 3'd0) begin errors++; $display("FAIL %s out_col got %0d want 0", tag, bus.out_col); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL %s busy got %0b want 0", tag, bus.busy); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL %s done got %0b want 0", tag, bus.done); end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check_reset_outputs("reset");
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_ones();
    load_weights(1'b0);
    write_w(9, 55);
    start_pass(0);
    @(negedge clk);
    checks += 3;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL first_busy got %0b want 1", bus.busy); end
    if (bus.pix_rd_en !== 1'b1) begin errors++; $display("FAIL first_read got %0b want 1", bus.pix_rd_en); end
    if (bus.pix_addr !== 6'd0) begin errors++; $display("FAIL first_addr got %0d want 0", bus.pix_addr); end
    @(negedge clk);
    checks += 2;
    if (bus.mul_valid !== 1'b1) begin errors++; $display("FAIL first_mul_valid got %0b want 1", bus.mul_valid); end
    if (bus.mul_b !== 8'd1) begin errors++; $display("FAIL first_mul_b got %0d want 1", bus.mul_b); end
    wait_done(326);
  endtask

  task automatic test_center();
    load_weights(1'b1);
    start_pass(0);
    wait_done(326);
  endtask

  task automatic test_stall();
    load_weights(1'b0);
    mv_cnt = 0; mv_lo = 2; mv_hi = 13;
    start_pass(3);
    advance_to(4);
    bus.stall = 1'b1;
    advance_to(7);
    bus.stall = 1'b0;
    wait_done(329);
    mv_hi = -1;
    checks++;
    if (mv_cnt != 9) begin errors++; $display("FAIL stall_tap_count got %0d want 9", mv_cnt); end
  endtask

  task automatic test_back_to_back_perturb();
    start_pass(0);
    advance_to(100);
    bus.start = 1'b1; bus.w_wr_en = 1'b1; bus.w_addr = 4'd0; bus.w_data = 8'd77;
    tick();
    bus.start = 1'b0; bus.w_wr_en = 1'b0;
    wait_done(326);
  endtask

  task automatic test_reset_mid();
    start_pass(0);
    advance_to(50);
    rst = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    expq.delete();
    tick(); tick();
    rst = 1'b1;
    tick();
    load_weights(1'b0);
    start_pass(0);
    wait_done(326);
  endtask

  initial begin
    bus.start = 1'b0; bus.stall = 1'b0; bus.w_wr_en = 1'b0;
    bus.w_addr = 4'd0; bus.w_data = 8'd0;
    for (int k = 0; k < 9; k++) wt[k] = 0;
    test_reset();
    test_ones();
    test_center();
    test_stall();
    test_back_to_back_perturb();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
